// File: rtl/lab1_g14_sweep_ctrl_if.sv
// Bundle between the sweep controller and its environment: start source,
// lab-function inputs/output and the sweep results.
interface lab1_g14_sweep_ctrl_if;
  logic        start;
  logic        y;
  logic        g;
  logic        t;
  logic        u;
  logic        e;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [4:0]  ones_cnt;
  logic [15:0] expected;
  logic        mismatch;
  logic [3:0]  first_err_idx;

  modport master (
    input  start, y, expected,
    output g, t, u, e, busy, done, truth_table, ones_cnt, mismatch, first_err_idx
  );

  modport slave (
    output start, y, expected,
    input  g, t, u, e, busy, done, truth_table, ones_cnt, mismatch, first_err_idx
  );
endinterface

// File: rtl/lab1_g14_sweep_ctrl.sv
// Steps a 4-input lab function through vectors 0..15, captures y into a truth table.
// Optional reference compare enabled by defining LAB1_G14_SWEEP_COMPARE_EN.
module lab1_g14_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  lab1_g14_sweep_ctrl_if.master        sif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Counter runs SETTLE_LOAD..0, giving SETTLE_CYCLES DRIVE cycles per vector
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0]  state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [7:0]  settle_cnt_r, settle_cnt_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [15:0] tt_r, tt_s;
  logic [4:0]  ones_r, ones_s;
  logic        accept_s;

  assign accept_s = (state_r == ST_IDLE) && sif.start;

  // Next-state and datapath update for the sweep sequencer
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    settle_cnt_s = settle_cnt_r;
    tt_s         = tt_r;
    ones_s       = ones_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s      = ST_DRIVE;
          idx_s        = 4'd0;
          tt_s         = 16'h0000;
          ones_s       = 5'd0;
          settle_cnt_s = SETTLE_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (settle_cnt_r == 8'd0) begin
          state_s = ST_SAMPLE;
        end else begin
          settle_cnt_s = settle_cnt_r - 8'd1;
        end
      end
      ST_SAMPLE: begin
        tt_s[idx_r] = sif.y;
        ones_s      = ones_r + {4'b0000, sif.y};
        if (idx_r == 4'd15) begin
          state_s = ST_DONE;
        end else begin
          idx_s        = idx_r + 4'd1;
          settle_cnt_s = SETTLE_LOAD;
          state_s      = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s == ST_DRIVE) || (state_s == ST_SAMPLE);
    done_s = (state_s == ST_DONE);
  end

  // Sequencer state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= 4'd0;
      settle_cnt_r <= 8'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      tt_r         <= 16'h0000;
      ones_r       <= 5'd0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      settle_cnt_r <= settle_cnt_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      tt_r         <= tt_s;
      ones_r       <= ones_s;
    end
  end

  assign sif.g           = idx_r[3];
  assign sif.t           = idx_r[2];
  assign sif.u           = idx_r[1];
  assign sif.e           = idx_r[0];
  assign sif.busy        = busy_r;
  assign sif.done        = done_r;
  assign sif.truth_table = tt_r;
  assign sif.ones_cnt    = ones_r;

`ifdef LAB1_G14_SWEEP_COMPARE_EN
  logic       mismatch_r, mismatch_s;
  logic [3:0] first_err_r, first_err_s;

  // First mismatch against the reference wins; later ones never overwrite it
  always_comb begin
    mismatch_s  = mismatch_r;
    first_err_s = first_err_r;
    if (accept_s) begin
      mismatch_s  = 1'b0;
      first_err_s = 4'd0;
    end else if ((state_r == ST_SAMPLE) && !mismatch_r && (sif.y != sif.expected[idx_r])) begin
      mismatch_s  = 1'b1;
      first_err_s = idx_r;
    end else begin
      mismatch_s  = mismatch_r;
      first_err_s = first_err_r;
    end
  end

  // Compare result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_r  <= 1'b0;
      first_err_r <= 4'd0;
    end else begin
      mismatch_r  <= mismatch_s;
      first_err_r <= first_err_s;
    end
  end

  assign sif.mismatch      = mismatch_r;
  assign sif.first_err_idx = first_err_r;
`else
  logic unused_expected_s;
  assign unused_expected_s  = ^sif.expected;
  assign sif.mismatch       = 1'b0;
  assign sif.first_err_idx  = 4'd0;
`endif

endmodule

// File: tb/tb_lab1_g14_sweep_ctrl.sv
// Scoreboard bench for lab1_g14_sweep_ctrl: stimulus pushes expected sweeps,
// a negedge monitor checks stepping, latency and results when done pulses.
module tb_lab1_g14_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lab1_g14_sweep_ctrl_if if0();
  lab1_g14_sweep_ctrl_if if1();

  lab1_g14_sweep_ctrl #(.SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .sif(if0));
  lab1_g14_sweep_ctrl #(.SETTLE_CYCLES(3)) dut1 (.clk(clk), .rst_n(rst_n), .sif(if1));

  int          mode = 0;
  logic [15:0] exp_in = 16'hF888;

  function automatic logic yfun(input int m, input logic [3:0] v);
    case (m)
      0:       return (v[3] & v[2]) | (v[1] & v[0]);
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return v[0];
      default: return 1'b0;
    endcase
  endfunction

  assign if0.y        = yfun(mode, {if0.g, if0.t, if0.u, if0.e});
  assign if1.y        = yfun(mode, {if1.g, if1.t, if1.u, if1.e});
  assign if0.expected = exp_in;
  assign if1.expected = exp_in;

  logic [1:0]  busy_a, done_a, mm_a;
  logic [3:0]  vec_a [2];
  logic [15:0] tt_a  [2];
  logic [4:0]  ones_a[2];
  logic [3:0]  fe_a  [2];
  assign busy_a   = {if1.busy, if0.busy};
  assign done_a   = {if1.done, if0.done};
  assign mm_a     = {if1.mismatch, if0.mismatch};
  assign vec_a[0] = {if0.g, if0.t, if0.u, if0.e};
  assign vec_a[1] = {if1.g, if1.t, if1.u, if1.e};
  assign tt_a[0]  = if0.truth_table;
  assign tt_a[1]  = if1.truth_table;
  assign ones_a[0] = if0.ones_cnt;
  assign ones_a[1] = if1.ones_cnt;
  assign fe_a[0]  = if0.first_err_idx;
  assign fe_a[1]  = if1.first_err_idx;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          inst;
    int          settle;
    int          acc;
    logic [15:0] tt;
    logic [4:0]  ones;
    logic        mm;
    logic [3:0]  fidx;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int inst, input int settle, input int acc, input logic [15:0] tt);
    exp_t r;
    logic [15:0] diff;
    r.inst = inst; r.settle = settle; r.acc = acc; r.tt = tt;
    r.ones = 5'd0;
    for (int i = 0; i < 16; i++) r.ones = r.ones + {4'b0000, tt[i]};
    r.mm = 1'b0; r.fidx = 4'd0;
`ifdef LAB1_G14_SWEEP_COMPARE_EN
    diff = tt ^ exp_in;
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) begin r.mm = 1'b1; r.fidx = 4'(i); end
    end
`else
    diff = 16'h0000;
`endif
    return r;
  endfunction

  // Monitor: per-cycle stepping checks, then full result check at done
  always @(negedge clk) begin : mon
    exp_t h;
    int k, per, n;
    if (rst_n && sb.size() > 0) begin
      h   = sb[0];
      n   = h.inst;
      k   = cyc - h.acc;
      per = 16 * (h.settle + 1);
      if (k >= 0 && k < per) begin
        chk("busy_in_sweep", 32'(busy_a[n]), 32'd1);
        chk("no_early_done", 32'(done_a[n]), 32'd0);
        chk("vector_step", 32'(vec_a[n]), 32'(k / (h.settle + 1)));
      end else if (k == per) begin
        chk("done_latency", 32'(done_a[n]), 32'd1);
        chk("busy_at_done", 32'(busy_a[n]), 32'd0);
        chk("truth_table", 32'(tt_a[n]), 32'(h.tt));
        chk("ones_cnt", 32'(ones_a[n]), 32'(h.ones));
        chk("mismatch", 32'(mm_a[n]), 32'(h.mm));
        chk("first_err_idx", 32'(fe_a[n]), 32'(h.fidx));
        chk("vector_at_done", 32'(vec_a[n]), 32'd15);
        void'(sb.pop_front());
      end
    end
  end

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) if0.start = v;
    else           if1.start = v;
  endtask

  task automatic check_reset(input int inst);
    chk("rst_busy", 32'(busy_a[inst]), 32'd0);
    chk("rst_done", 32'(done_a[inst]), 32'd0);
    chk("rst_tt", 32'(tt_a[inst]), 32'd0);
    chk("rst_ones", 32'(ones_a[inst]), 32'd0);
    chk("rst_vec", 32'(vec_a[inst]), 32'd0);
    chk("rst_mismatch", 32'(mm_a[inst]), 32'd0);
    chk("rst_first_err", 32'(fe_a[inst]), 32'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("sweep_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_sweep(input int inst, input int settle, input logic [15:0] tt);
    int acc;
    @(negedge clk);
    set_start(inst, 1'b1);
    @(posedge clk);
    #1;
    acc = cyc;
    sb.push_back(mk(inst, settle, acc, tt));
    set_start(inst, 1'b0);
    chk("start_clears_tt", 32'(tt_a[inst]), 32'd0);
    chk("start_clears_ones", 32'(ones_a[inst]), 32'd0);
    wait_done();
    repeat (2) @(negedge clk);
    chk("hold_vector_1111", 32'(vec_a[inst]), 32'd15);
    chk("hold_truth_table", 32'(tt_a[inst]), 32'(tt));
    chk("idle_done_low", 32'(done_a[inst]), 32'd0);
  endtask

  initial begin : stim
    int acc;
    if0.start = 1'b0;
    if1.start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal sweep, then constant-0 and constant-1 sweeps
    mode = 0; run_sweep(0, 1, 16'hF888);
    mode = 1; run_sweep(0, 1, 16'h0000);
    mode = 2; run_sweep(0, 1, 16'hFFFF);

    // Longer settle with y = e
    mode = 3; run_sweep(1, 3, 16'hAAAA);

    // start held high through a sweep: next accept lands two edges after done
    mode = 0;
    @(negedge clk);
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    sb.push_back(mk(0, 1, acc, 16'hF888));
    sb.push_back(mk(0, 1, acc + 34, 16'hF888));
    while (cyc < acc + 34) @(negedge clk);
    if0.start = 1'b0;
    wait_done();

    // Reset while vector 6 is driven
    @(negedge clk);
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    for (int i = 0; i < 100 && vec_a[0] != 4'd6; i++) @(negedge clk);
    chk("reached_vector_6", 32'(vec_a[0]), 32'd6);
    sb.delete();
    rst_n = 1'b0;
    #1;
    check_reset(0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 1, 16'hF888);

    // Reference compare patterns (mismatch stays 0 when the feature is absent)
    exp_in = 16'hF880; run_sweep(0, 1, 16'hF888);
    exp_in = 16'h7880; run_sweep(0, 1, 16'hF888);
    exp_in = 16'hF888; run_sweep(0, 1, 16'hF888);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lab1_g14_sweep_ctrl.md
Name: lab1_g14_sweep_ctrl

Overview:
Sequencer that drives the 4-input combinational lab function (inputs g,t,u,e; output y) through all 16 input combinations in ascending order. It waits a programmable settle time per vector and captures y into a 16-bit truth-table register. It also counts the ones in y and signals completion with a one-cycle done pulse. It sits between a start source (button or bench) and one instance of the lab function, replacing hand-written stimulus sequences in hardware.

Parameters:
SETTLE_CYCLES, 1, cycles each vector is held before y is sampled; legal range 1..255; 8-bit internal counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level/pulse; sampled only in IDLE
y  input  1  output of lab function under control
g  output  1  function input, vector bit 3 (MSB)
t  output  1  function input, vector bit 2
u  output  1  function input, vector bit 1
e  output  1  function input, vector bit 0 (LSB)
busy  output  1  high while sweep in progress (DRIVE/SAMPLE)
done  output  1  one-cycle pulse when sweep completes
truth_table  output  16  bit i = y captured for vector i
ones_cnt  output  5  number of 1s in truth_table (0..16)
expected  input  16  reference truth table (used only with optional feature)
mismatch  output  1  compare result (optional feature)
first_err_idx  output  4  lowest mismatching vector index (optional feature)

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low (rst_n), assert async, deassert sync to clk.
- Reset values: state=IDLE, idx=0, settle counter=0, {g,t,u,e}=0000, busy=0, done=0, truth_table=0, ones_cnt=0, mismatch=0, first_err_idx=0.
- {g,t,u,e} = idx at all times; registered outputs, no combinational path from start or y.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: when start=1 on a clock edge, go to DRIVE. On that edge also set idx=0, truth_table=0, ones_cnt=0, mismatch=0, first_err_idx=0, and load the settle counter.
- DRIVE: busy=1. The settle counter counts SETTLE_CYCLES cycles, then the FSM goes to SAMPLE.
- SAMPLE: busy=1. Set truth_table[idx] <= y and ones_cnt <= ones_cnt + y.
  - If idx==15, go to DONE; idx holds at 15.
  - Otherwise idx <= idx+1, reload the settle counter, and go to DRIVE.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditional return to IDLE. start is ignored in DONE.
- Latency: from the edge that accepts start to the cycle done is high = 16*(SETTLE_CYCLES+1) cycles; 32 cycles at default.
- y is sampled in the SAMPLE cycle only. Changes on y during DRIVE have no effect.
- start while busy or in DONE is ignored; there is no restart or abort except reset.
- Results: truth_table, ones_cnt, mismatch and first_err_idx hold after done until the next accepted start.
- {g,t,u,e} remains 1111 after a sweep until the next start.
- ones_cnt reaches at most 16, so 5 bits never wrap.
- Reset mid-sweep: immediate return to all reset values; partial results are discarded.

Optional Feature:
Macro LAB1_G14_SWEEP_COMPARE_EN.
- Defined: in each SAMPLE cycle, if y != expected[idx] and no earlier mismatch in this sweep, set mismatch <= 1 and first_err_idx <= idx. The first mismatch wins and later ones do not overwrite it. Both outputs are cleared at start accept and valid when done pulses. expected must be stable from start until done.
- Undefined: no compare logic; mismatch and first_err_idx are tied to 0 and expected is ignored.

Test Plan:
- Nominal sweep, y modelled as (g&t)|(u&e), SETTLE_CYCLES=1, one-cycle start pulse -> truth_table=16'hF888, ones_cnt=7, done pulses exactly 32 cycles after start accept, busy high for 32 cycles, g,t,u,e step 0000..1111.
- Constant y=0, then a second sweep with y=1 -> first sweep gives 16'h0000 and ones_cnt 0; second gives 16'hFFFF and ones_cnt 16; truth_table is cleared at the second start.
- SETTLE_CYCLES=3 with y=e -> truth_table=16'hAAAA, ones_cnt=8, done 64 cycles after start; each vector is held 3 cycles before sampling.
- start held high continuously and re-pulsed mid-sweep -> no restart while busy; a new sweep begins on the edge after done, when back in IDLE.
- rst_n driven low at vector 6 -> all outputs return to reset values immediately; the next start gives a complete, correct sweep.
- With LAB1_G14_SWEEP_COMPARE_EN, y=(g&t)|(u&e) -> expected=16'hF888 gives mismatch=0; expected=16'hF880 gives mismatch=1 and first_err_idx=3; expected=16'h7880 gives first_err_idx=3, not 15.
